// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key schedule: one expanded word per clock into a word store,
// with a registered round-key read port that serves keys as soon as their words exist.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = x;
        for (int b = 0; b < 8; b++) begin
            if (y[b]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (maps 0 to 0 as the S-box requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r;
        logic [7:0] q;
        r = 8'h01;
        q = x;
        for (int k = 1; k < 8; k++) begin
            q = gf_mul(q, q);
            r = gf_mul(r, q);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv = gf_inv(a);
        s   = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                  ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
endmodule

module aes_key_schedule_seq #(
    parameter int KEY_W = 256,
    parameter int RK_W  = 128
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             key_valid_i,
    output logic             key_ready_o,
    input  logic [1:0]       key_len_i,
    input  logic [KEY_W-1:0] key_i,
    output logic             key_err_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [3:0]       nr_o,
    input  logic             rk_rd_i,
    input  logic [3:0]       rk_idx_i,
    output logic             rk_valid_o,
    output logic [RK_W-1:0]  rk_o
);
    localparam int DEPTH = 4 * (KEY_W / 32 + 7);
    localparam int AW    = $clog2(DEPTH);
    localparam int KW    = KEY_W / 32;

    if (RK_W != 128) begin : g_rk_w_check
        $error("aes_key_schedule_seq: RK_W must be 128");
    end

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    state_t         state_q, state_d;
    logic [31:0]    w_mem [DEPTH];
    logic [AW-1:0]  wr_cnt_q;
    logic [2:0]     pos_q;
    logic [7:0]     rcon_q;
    logic [3:0]     nk_q;
    logic [3:0]     nk_sel;
    logic           accept, key_bad, key_load;
    logic [31:0]    w_prev, w_nk, sub_in, sub_out, temp, w_new;
    logic [AW-1:0]  last_idx, rk_last, rk_base;

    assign key_ready_o = (state_q != EXPAND);
    assign busy_o      = (state_q == EXPAND);
    assign done_o      = (state_q == DONE);

    always_comb begin
        nk_sel = 4'd4;
        case (key_len_i)
            2'b01:   nk_sel = 4'd6;
            2'b10:   nk_sel = 4'd8;
            default: nk_sel = 4'd4;
        endcase
    end

    assign accept   = key_valid_i & key_ready_o;
    assign key_bad  = (key_len_i == 2'b11) || (32 * int'(nk_sel) > KEY_W);
    assign key_load = accept & ~key_bad;
    assign last_idx = AW'({nr_o, 2'b11});

    // Expansion datapath: w[i] = w[i-Nk] ^ temp, temp chosen by the position within Nk.
    assign w_prev = w_mem[wr_cnt_q - AW'(1)];
    assign w_nk   = w_mem[wr_cnt_q - AW'(nk_q)];
    assign sub_in = (pos_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .s(sub_out[8*g +: 8]));
    end

    always_comb begin
        temp = w_prev;
        if (pos_q == 3'd0)
            temp = sub_out ^ {rcon_q, 24'h0};
        else if (nk_q == 4'd8 && pos_q == 3'd4)
            temp = sub_out;
        w_new = w_nk ^ temp;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (key_load) state_d = EXPAND;
            EXPAND:     if (wr_cnt_q == last_idx) state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_cnt_q  <= '0;
            pos_q     <= 3'd0;
            rcon_q    <= 8'h01;
            nk_q      <= 4'd4;
            nr_o      <= 4'd0;
            key_err_o <= 1'b0;
        end else begin
            key_err_o <= accept & key_bad;
            if (key_load) begin
                nk_q     <= nk_sel;
                nr_o     <= nk_sel + 4'd6;
                wr_cnt_q <= AW'(nk_sel);
                pos_q    <= 3'd0;
                rcon_q   <= 8'h01;
            end else if (state_q == EXPAND) begin
                wr_cnt_q <= wr_cnt_q + AW'(1);
                pos_q    <= ({1'b0, pos_q} == nk_q - 4'd1) ? 3'd0 : pos_q + 3'd1;
                if (pos_q == 3'd0)
                    rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
            end
        end
    end

    // The word store is deliberately not reset; validity is tracked by wr_cnt_q alone.
    always_ff @(posedge clk_i) begin
        if (key_load) begin
            for (int j = 0; j < KW; j++) begin
                if (j < int'(nk_sel))
                    w_mem[AW'(j)] <= key_i[KEY_W-1-32*j -: 32];
            end
        end else if (state_q == EXPAND) begin
            w_mem[wr_cnt_q] <= w_new;
        end
    end

    assign rk_last = AW'({rk_idx_i, 2'b11});
    assign rk_base = AW'({rk_idx_i, 2'b00});

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rk_valid_o <= 1'b0;
            rk_o       <= '0;
        end else begin
            rk_valid_o <= 1'b0;
            if (rk_rd_i && (rk_idx_i <= nr_o) && (wr_cnt_q > rk_last)) begin
                rk_valid_o <= 1'b1;
                rk_o       <= {w_mem[rk_base], w_mem[rk_base + AW'(1)],
                               w_mem[rk_base + AW'(2)], w_mem[rk_base + AW'(3)]};
            end
        end
    end
endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed bench for aes_key_schedule_seq using the FIPS-197 appendix A expansion vectors.

module tb_aes_key_schedule_seq;
    logic         clk_i = 1'b0;
    logic         rst_n_i;
    logic         key_valid_i;
    logic         key_ready_o;
    logic [1:0]   key_len_i;
    logic [255:0] key_i;
    logic         key_err_o;
    logic         busy_o;
    logic         done_o;
    logic [3:0]   nr_o;
    logic         rk_rd_i;
    logic [3:0]   rk_idx_i;
    logic         rk_valid_o;
    logic [127:0] rk_o;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;
    int acc_cyc   = 0;
    int lat;
    logic         v;
    logic [127:0] k;

    localparam logic [127:0] KEY128  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] KEY192  = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] KEY256  = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [127:0] RK128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] RK128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] RK192_12 = 128'he98ba06f448c773c8ecc720401002202;
    localparam logic [127:0] RK256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

    aes_key_schedule_seq #(.KEY_W(256), .RK_W(128)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .key_valid_i(key_valid_i), .key_ready_o(key_ready_o),
        .key_len_i(key_len_i), .key_i(key_i), .key_err_o(key_err_o),
        .busy_o(busy_o), .done_o(done_o), .nr_o(nr_o),
        .rk_rd_i(rk_rd_i), .rk_idx_i(rk_idx_i),
        .rk_valid_o(rk_valid_o), .rk_o(rk_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    endtask

    // Offer one key for one cycle; returns at the negedge just after the acceptance edge.
    task automatic applyStimulus(input logic [1:0] len, input logic [255:0] key);
        @(negedge clk_i);
        key_valid_i = 1'b1;
        key_len_i   = len;
        key_i       = key;
        @(negedge clk_i);
        key_valid_i = 1'b0;
        acc_cyc     = cyc;
    endtask

    task automatic readRound(input logic [3:0] r, output logic valid, output logic [127:0] rk);
        rk_rd_i  = 1'b1;
        rk_idx_i = r;
        @(negedge clk_i);
        valid   = rk_valid_o;
        rk      = rk_o;
        rk_rd_i = 1'b0;
    endtask

    task automatic waitDone(output int latency);
        int guard = 0;
        while (done_o !== 1'b1 && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        latency = cyc - acc_cyc;
    endtask

    initial begin
        rst_n_i = 1'b0; key_valid_i = 1'b0; key_len_i = 2'b00; key_i = '0;
        rk_rd_i = 1'b0; rk_idx_i = 4'd0;
        #12;
        checkOutput("reset_ready", key_ready_o, 1);
        checkOutput("reset_busy", busy_o, 0);
        checkOutput("reset_done", done_o, 0);
        checkOutput("reset_nr", nr_o, 0);
        checkOutput("reset_rkvalid", rk_valid_o, 0);
        checkOutput("reset_rk", rk_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        $display("[TB] AES-128");
        applyStimulus(2'b00, {KEY128, 128'h0});
        checkOutput("a128_busy", busy_o, 1);
        checkOutput("a128_ready", key_ready_o, 0);
        waitDone(lat);
        checkOutput("a128_latency", lat, 40);
        checkOutput("a128_nr", nr_o, 10);
        readRound(4'd10, v, k);
        checkOutput("a128_r10_valid", v, 1);
        checkOutput("a128_r10", k, RK128_10);
        readRound(4'd0, v, k);
        checkOutput("a128_r0", k, KEY128);
        readRound(4'd11, v, k);
        checkOutput("a128_r11_invalid", v, 0);

        $display("[TB] reserved key length");
        applyStimulus(2'b11, {KEY128, 128'h0});
        checkOutput("err_pulse", key_err_o, 1);
        checkOutput("err_done", done_o, 1);
        checkOutput("err_nr", nr_o, 10);
        @(negedge clk_i);
        checkOutput("err_pulse_end", key_err_o, 0);
        readRound(4'd10, v, k);
        checkOutput("err_r10_kept", k, RK128_10);

        $display("[TB] AES-192");
        applyStimulus(2'b01, {KEY192, 64'h0});
        waitDone(lat);
        checkOutput("a192_latency", lat, 46);
        checkOutput("a192_nr", nr_o, 12);
        readRound(4'd12, v, k);
        checkOutput("a192_r12_valid", v, 1);
        checkOutput("a192_r12", k, RK192_12);

        $display("[TB] AES-256 with key offered during expansion");
        applyStimulus(2'b10, KEY256);
        key_valid_i = 1'b1; key_len_i = 2'b00; key_i = {KEY128, 128'h0};
        repeat (5) @(negedge clk_i);
        key_valid_i = 1'b0;
        waitDone(lat);
        checkOutput("a256_latency", lat, 52);
        checkOutput("a256_nr", nr_o, 14);
        readRound(4'd14, v, k);
        checkOutput("a256_r14_valid", v, 1);
        checkOutput("a256_r14", k, RK256_14);

        $display("[TB] streaming reads");
        applyStimulus(2'b00, {KEY128, 128'h0});
        repeat (4) @(negedge clk_i);
        readRound(4'd1, v, k);
        checkOutput("stream_r1_valid", v, 1);
        checkOutput("stream_r1", k, RK128_1);
        readRound(4'd5, v, k);
        checkOutput("stream_r5_invalid", v, 0);
        checkOutput("stream_rk_held", k, RK128_1);
        waitDone(lat);
        checkOutput("stream_latency", lat, 40);

        $display("[TB] reset during AES-256 expansion");
        applyStimulus(2'b10, KEY256);
        repeat (19) @(negedge clk_i);
        rst_n_i = 1'b0;
        #1;
        checkOutput("rst_ready", key_ready_o, 1);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_nr", nr_o, 0);
        checkOutput("rst_err", key_err_o, 0);
        checkOutput("rst_rk", rk_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        readRound(4'd0, v, k);
        checkOutput("rst_r0_invalid", v, 0);
        applyStimulus(2'b00, {KEY128, 128'h0});
        waitDone(lat);
        checkOutput("rst_a128_latency", lat, 40);
        readRound(4'd10, v, k);
        checkOutput("rst_a128_r10_valid", v, 1);
        checkOutput("rst_a128_r10", k, RK128_10);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
